// File: rtl/dpram_cmd_engine.sv
// rtl/dpram_cmd_engine.sv - s2-port command engine for the HPS/FPGA shared dual-port RAM
module dpram_cmd_engine #(
    parameter int POLL_CYCLES = 256,
    parameter int RD_LAT      = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    output logic [1:0]  ram_address,
    output logic        ram_chipselect,
    output logic        ram_clken,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    output logic [3:0]  ram_byteenable,
    input  logic [31:0] ram_readdata,
    output logic        busy,
    output logic        done_pulse,
    output logic        error,
    output logic [7:0]  cmd_count
);

    typedef enum logic [3:0] {
        IDLE, RD_CMD, W_CMD, RD_A, W_A, RD_B, W_B, EXEC, MUL, WR_RES, WR_CMD
    } state_t;

    localparam int              TW         = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(POLL_CYCLES - 1);
    localparam logic            LAT_LAST   = 1'(RD_LAT - 1);

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           lat_q, lat_d;
    logic [3:0]     opcode_q, opcode_d;
    logic [31:0]    opa_q, opa_d;
    logic [31:0]    opb_q, opb_d;
    logic [31:0]    result_q, result_d;
    logic [4:0]     mul_cnt_q, mul_cnt_d;
    logic           busy_q, busy_d;
    logic           error_q, error_d;
    logic           err_cmd_q, err_cmd_d;
    logic [7:0]     cmd_count_q, cmd_count_d;
    logic           clken_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            lat_q       <= 1'b0;
            opcode_q    <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            mul_cnt_q   <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            err_cmd_q   <= 1'b0;
            cmd_count_q <= '0;
            clken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lat_q       <= lat_d;
            opcode_q    <= opcode_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            mul_cnt_q   <= mul_cnt_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            err_cmd_q   <= err_cmd_d;
            cmd_count_q <= cmd_count_d;
            clken_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        lat_d          = lat_q;
        opcode_d       = opcode_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        result_d       = result_q;
        mul_cnt_d      = mul_cnt_q;
        busy_d         = busy_q;
        error_d        = error_q;
        err_cmd_d      = err_cmd_q;
        cmd_count_d    = cmd_count_q;
        done_pulse     = 1'b0;
        ram_address    = 2'd0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = 32'd0;
        ram_byteenable = 4'h0;

        case (state_q)
            IDLE: begin
                if (!enable) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = RD_CMD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RD_CMD: begin
                ram_chipselect = 1'b1;
                ram_byteenable = 4'hF;
                ram_address    = 2'd0;
                lat_d          = 1'b0;
                state_d        = W_CMD;
            end
            // Each W_* state waits RD_LAT cycles, sampling readdata on the last one.
            W_CMD: begin
                if (lat_q == LAT_LAST) begin
                    if (ram_readdata[31]) begin
                        opcode_d = ram_readdata[3:0];
                        busy_d   = 1'b1;
                        state_d  = RD_A;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RD_A: begin
                ram_chipselect = 1'b1;
                ram_byteenable = 4'hF;
                ram_address    = 2'd1;
                lat_d          = 1'b0;
                state_d        = W_A;
            end
            W_A: begin
                if (lat_q == LAT_LAST) begin
                    opa_d   = ram_readdata;
                    state_d = RD_B;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RD_B: begin
                ram_chipselect = 1'b1;
                ram_byteenable = 4'hF;
                ram_address    = 2'd2;
                lat_d          = 1'b0;
                state_d        = W_B;
            end
            W_B: begin
                if (lat_q == LAT_LAST) begin
                    opb_d   = ram_readdata;
                    state_d = EXEC;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            EXEC: begin
                err_cmd_d = 1'b0;
                state_d   = WR_RES;
                case (opcode_q)
                    4'd0: result_d = 32'd0;
                    4'd1: result_d = opa_q + opb_q;
                    4'd2: result_d = opa_q - opb_q;
                    4'd3: result_d = opa_q & opb_q;
                    4'd4: result_d = opa_q | opb_q;
                    4'd5: result_d = opa_q ^ opb_q;
                    4'd6: begin
                        result_d  = 32'd0;
                        mul_cnt_d = 5'd0;
                        state_d   = MUL;
                    end
                    4'd7: result_d = opa_q << opb_q[4:0];
                    default: begin
                        result_d  = 32'd0;
                        err_cmd_d = 1'b1;
                        error_d   = 1'b1;
                    end
                endcase
            end
            // result_q doubles as the accumulator; operands are consumed in place.
            MUL: begin
                if (opb_q[0]) begin
                    result_d = result_q + opa_q;
                end
                opa_d     = opa_q << 1;
                opb_d     = opb_q >> 1;
                mul_cnt_d = mul_cnt_q + 5'd1;
                if (mul_cnt_q == 5'd31) begin
                    state_d = WR_RES;
                end
            end
            WR_RES: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'hF;
                ram_address    = 2'd3;
                ram_writedata  = result_q;
                state_d        = WR_CMD;
            end
            WR_CMD: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'hF;
                ram_address    = 2'd0;
                ram_writedata  = {1'b0, 1'b1, err_cmd_q, 25'd0, opcode_q};
                done_pulse     = 1'b1;
                cmd_count_d    = cmd_count_q + 8'd1;
                busy_d         = 1'b0;
                timer_d        = '0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_clken = clken_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_dpram_cmd_engine.sv
// tb/tb_dpram_cmd_engine.sv - directed scoreboard bench for dpram_cmd_engine
module tb_dpram_cmd_engine;

    localparam int POLL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_clken;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_readdata;
    logic        busy;
    logic        done_pulse;
    logic        error;
    logic [7:0]  cmd_count;

    logic        hps_we = 1'b0;
    logic [1:0]  hps_addr = 2'd0;
    logic [31:0] hps_wdata = 32'd0;
    logic [31:0] mem [4] = '{default: 32'd0};
    logic [31:0] rdata = 32'd0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] cmd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rd0 = -1;
    int rd0_period = 0;
    int rd0_count = 0;
    int wr_count = 0;
    int cs_viol = 0;
    int be_viol = 0;
    int done_count = 0;
    int done_lat = 0;
    logic       cs_prev = 1'b0;
    logic       wr_prev = 1'b0;
    logic [1:0] addr_prev = 2'd0;

    dpram_cmd_engine #(.POLL_CYCLES(POLL), .RD_LAT(1)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .enable         (enable),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_clken      (ram_clken),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_readdata   (ram_readdata),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .error          (error),
        .cmd_count      (cmd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port RAM model: HPS side is a plain write port, s2 has one cycle of read latency.
    always @(posedge clk) begin
        if (hps_we) mem[hps_addr] <= hps_wdata;
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                rdata <= mem[ram_address];
            end
        end
    end
    assign ram_readdata = rdata;

    always @(negedge clk) begin
        if (ram_chipselect && !ram_write && ram_address == 2'd0) begin
            if (last_rd0 >= 0) rd0_period = cyc - last_rd0;
            last_rd0 = cyc;
            rd0_count++;
        end
        if (ram_chipselect && ram_write) wr_count++;
        if (ram_chipselect && ram_byteenable != 4'hF) be_viol++;
        if (ram_chipselect && cs_prev && ram_address == addr_prev && ram_write == wr_prev) cs_viol++;
        cs_prev   = ram_chipselect;
        wr_prev   = ram_write;
        addr_prev = ram_address;
        if (done_pulse) begin
            done_count++;
            done_lat = cyc - last_rd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hps_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        hps_we = 1'b1; hps_addr = a; hps_wdata = d;
        @(negedge clk);
        hps_we = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_pulse) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_compare(input string tag);
        bit   ok;
        exp_t e;
        wait_done(ok);
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_word3"}, mem[3], e.res);
            check({tag, "_word0"}, mem[0], e.cmd);
            check({tag, "_latency"}, 32'(done_lat), 32'(e.lat));
        end
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic err_flag);
        exp_t e;
        hps_write(2'd1, a);
        hps_write(2'd2, b);
        e.res = res;
        e.cmd = {1'b0, 1'b1, err_flag, 25'd0, op};
        e.lat = (op == 4'd6) ? 40 : 8;
        sb.push_back(e);
        hps_write(2'd0, {1'b1, 27'd0, op});
        pop_compare(tag);
    endtask

    initial begin
        int d0;
        int r0;
        bit ok;
        exp_t e;

        rst_n  = 1'b0;
        enable = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(cmd_count), 32'd0);
        check("rst_cs", 32'(ram_chipselect), 32'd0);
        check("rst_clken", 32'(ram_clken), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("clken_after_reset", 32'(ram_clken), 32'd1);

        // Idle polling with GO clear
        enable = 1'b1;
        r0 = rd0_count;
        repeat (45) @(negedge clk);
        check("poll_reads", 32'(rd0_count - r0 >= 4), 32'd1);
        check("poll_period", 32'(rd0_period), 32'(POLL + 2));
        check("poll_no_writes", 32'(wr_count), 32'd0);
        check("poll_busy", 32'(busy), 32'd0);
        check("poll_count", 32'(cmd_count), 32'd0);

        d0 = done_count;
        run_cmd("add", 4'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0);
        check("add_pulses", 32'(done_count - d0), 32'd1);
        check("add_count", 32'(cmd_count), 32'd1);
        check("add_error", 32'(error), 32'd0);
        check("add_busy_clear", 32'(busy), 32'd0);

        run_cmd("mul", 4'd6, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0);
        run_cmd("shl", 4'd7, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1'b0);
        run_cmd("xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0);
        run_cmd("illegal", 4'hB, 32'd9, 32'd9, 32'd0, 1'b1);
        check("illegal_error", 32'(error), 32'd1);
        run_cmd("sub", 4'd2, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        check("sub_error_sticky", 32'(error), 32'd1);
        check("sub_count", 32'(cmd_count), 32'd6);

        // Reset during a multiply: no write-back, then the command re-runs
        hps_write(2'd1, 32'd3);
        hps_write(2'd2, 32'd5);
        hps_write(2'd0, 32'h8000_0006);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_busy_seen", 32'(ok), 32'd1);
        repeat (15) @(negedge clk);
        d0 = wr_count;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cs", 32'(ram_chipselect), 32'd0);
        check("abort_write", 32'(ram_write), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_count", 32'(cmd_count), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_writes", 32'(wr_count - d0), 32'd0);
        check("abort_word3", mem[3], 32'hFFFF_FFFE);
        check("abort_word0", mem[0], 32'h8000_0006);
        e.res = 32'd15;
        e.cmd = 32'h4000_0006;
        e.lat = 40;
        sb.push_back(e);
        rst_n = 1'b1;
        pop_compare("rerun");
        check("rerun_count", 32'(cmd_count), 32'd1);

        // Back-to-back ADDs across the counter wrap
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_count;
        for (int i = 0; i < 256; i++) begin
            run_cmd("b2b", 4'd1, 32'(i * 32'h0101_0101), 32'(3 * i + 1),
                    32'(i * 32'h0101_0101) + 32'(3 * i + 1), 1'b0);
            if (i == 254) check("count_255", 32'(cmd_count), 32'd255);
        end
        check("wrap_count", 32'(cmd_count), 32'd0);
        check("wrap_pulses", 32'(done_count - d0), 32'd256);
        check("cs_single_cycle", 32'(cs_viol), 32'd0);
        check("byteenable_full", 32'(be_viol), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // enable low keeps the block idle
        enable = 1'b0;
        r0 = rd0_count;
        repeat (30) @(negedge clk);
        check("disabled_no_poll", 32'(rd0_count - r0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
